// File: rtl/img_cmp_pkg.sv
// Shared definitions for the image compare engine: compare-mode codes and FSM encoding.
package img_cmp_pkg;

   localparam logic [2:0] MODE_ABSDIFF = 3'd0;
   localparam logic [2:0] MODE_MIN     = 3'd1;
   localparam logic [2:0] MODE_MAX     = 3'd2;
   localparam logic [2:0] MODE_XOR     = 3'd3;
   localparam logic [2:0] MODE_MASK    = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pix_ram.sv
// Simple dual-port pixel RAM: synchronous write, registered read.
module pix_ram #(
   parameter int DEPTH = 16,
   parameter int PW    = 24,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [PW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [PW-1:0] rdata
);

   logic [PW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is cleared; the array contents survive reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end

endmodule

// File: rtl/img_compare_engine.sv
// Two-buffer pixel compare engine: self-sequenced read of A/B, per-channel ALU,
// result buffer write and thresholded difference count.
module img_compare_engine
   import img_cmp_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CH    = 3,
   parameter int CW    = 8,
   parameter int AW    = $clog2(DEPTH),
   localparam int PW   = CH * CW
)(
   input  logic          clk50,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [PW-1:0] wr_data,
   input  logic          start,
   input  logic [2:0]    mode,
   input  logic [CW-1:0] threshold,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   diff_count,
   input  logic [AW-1:0] rd_addr,
   output logic [PW-1:0] rd_data
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state_reg, state_next;
   logic [2:0]    mode_reg;
   logic [CW-1:0] thr_reg;
   logic [AW-1:0] ptr_reg;
   logic [AW-1:0] addr1_reg;
   logic          valid1_reg;
   logic [AW:0]   diff_count_reg;
   logic          busy_reg;
   logic          done_reg;

   logic [PW-1:0] a_q, b_q;
   logic [PW-1:0] alu_pix, res_pix;
   logic [CH-1:0] exceed;

   logic load_ok;
   assign load_ok = wr_en && !busy_reg;

   pix_ram #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) u_ram_a (
      .clk(clk50), .rst(reset), .we(load_ok && !wr_sel), .waddr(wr_addr),
      .wdata(wr_data), .raddr(ptr_reg), .rdata(a_q)
   );

   pix_ram #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) u_ram_b (
      .clk(clk50), .rst(reset), .we(load_ok && wr_sel), .waddr(wr_addr),
      .wdata(wr_data), .raddr(ptr_reg), .rdata(b_q)
   );

   pix_ram #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) u_ram_res (
      .clk(clk50), .rst(reset), .we(valid1_reg), .waddr(addr1_reg),
      .wdata(res_pix), .raddr(rd_addr), .rdata(rd_data)
   );

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [CW-1:0] a, b, absd;
      assign a    = a_q[gi*CW +: CW];
      assign b    = b_q[gi*CW +: CW];
      assign absd = (a > b) ? (a - b) : (b - a);
      assign exceed[gi] = absd > thr_reg;
      assign alu_pix[gi*CW +: CW] = (mode_reg == MODE_MIN) ? ((a < b) ? a : b) :
                                    (mode_reg == MODE_MAX) ? ((a > b) ? a : b) :
                                    (mode_reg == MODE_XOR) ? (a ^ b) : absd;
   end

   assign res_pix = (mode_reg == MODE_MASK) ? {PW{|exceed}} : alu_pix;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (start) state_next = RUN;
         RUN:   if (ptr_reg == LAST) state_next = DRAIN;
         DRAIN: state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // busy spans the registered done pulse, which follows the DONE state by one cycle.
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         mode_reg       <= MODE_ABSDIFF;
         thr_reg        <= '0;
         ptr_reg        <= '0;
         addr1_reg      <= '0;
         valid1_reg     <= 1'b0;
         diff_count_reg <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg  <= state_next;
         busy_reg   <= (state_next != IDLE) || (state_reg == DONE);
         done_reg   <= (state_reg == DONE);
         valid1_reg <= (state_reg == RUN);
         addr1_reg  <= ptr_reg;
         if (state_reg == IDLE && start) begin
            mode_reg       <= mode;
            thr_reg        <= threshold;
            ptr_reg        <= '0;
            diff_count_reg <= '0;
         end else begin
            if (state_reg == RUN) ptr_reg <= ptr_reg + 1'b1;
            if (valid1_reg && (|exceed)) diff_count_reg <= diff_count_reg + 1'b1;
         end
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign diff_count = diff_count_reg;

endmodule

// File: tb/tb_img_compare_engine.sv
// Directed bench for img_compare_engine: default 16x24-bit instance plus a 64x12-bit sweep instance.
module tb_img_compare_engine;

   localparam int DEPTH = 16, CH = 3, CW = 8, AW = 4, PW = 24;
   localparam int D2 = 64, CW2 = 12, AW2 = 6;

   logic clk50 = 1'b0;
   logic reset = 1'b1;
   always #5 clk50 = ~clk50;

   logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [PW-1:0] wr_data = '0, rd_data;
   logic [2:0]    mode = 3'd0;
   logic [CW-1:0] threshold = '0;
   logic          busy, done;
   logic [AW:0]   diff_count;

   logic           s_wr_en = 1'b0, s_wr_sel = 1'b0, s_start = 1'b0;
   logic [AW2-1:0] s_wr_addr = '0, s_rd_addr = '0;
   logic [CW2-1:0] s_wr_data = '0, s_rd_data, s_threshold = '0;
   logic [2:0]     s_mode = 3'd0;
   logic           s_busy, s_done;
   logic [AW2:0]   s_diff_count;

   img_compare_engine #(.DEPTH(DEPTH), .CH(CH), .CW(CW)) dut (
      .clk50(clk50), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .mode(mode), .threshold(threshold), .busy(busy),
      .done(done), .diff_count(diff_count), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   img_compare_engine #(.DEPTH(D2), .CH(1), .CW(CW2)) dut_sweep (
      .clk50(clk50), .reset(reset), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .start(s_start), .mode(s_mode), .threshold(s_threshold),
      .busy(s_busy), .done(s_done), .diff_count(s_diff_count), .rd_addr(s_rd_addr),
      .rd_data(s_rd_data)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) $display("ok   %-14s value=%0h", tag, obs);
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic wr(input logic sel, input int addr, input logic [PW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
      @(negedge clk50);
      wr_en = 1'b0;
   endtask

   task automatic rd(input int addr, output logic [PW-1:0] d);
      rd_addr = AW'(addr);
      @(negedge clk50);
      d = rd_data;
   endtask

   task automatic launch(input logic [2:0] m, input logic [CW-1:0] t);
      mode = m; threshold = t; start = 1'b1;
      @(negedge clk50);
      start = 1'b0;
   endtask

   task automatic finish_run(input string tag);
      int lat = -1;
      for (int k = 1; k <= DEPTH + 10; k++) begin
         @(negedge clk50);
         if (done) begin lat = k; break; end
      end
      check({tag, "_lat"}, 64'(lat), 64'(DEPTH + 2));
      @(negedge clk50);
      check({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
   endtask

   function automatic logic [PW-1:0] pat(input int i);
      return PW'(32'h102030 * i);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [PW-1:0]  r;
   logic [PW-1:0]  acc;
   logic [CW2-1:0] ma [D2];
   logic [CW2-1:0] mb [D2];
   logic [CW2-1:0] e;
   int             cnt, ndone, lat2;

   initial begin
      repeat (2) @(negedge clk50);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_diff", 64'(diff_count), 64'd0);
      check("rst_rdata", 64'(rd_data), 64'd0);
      check("rst_s_busy", 64'(s_busy), 64'd0);
      reset = 1'b0;
      @(negedge clk50);

      for (int i = 0; i < DEPTH; i++) begin
         wr(1'b0, i, pat(i));
         wr(1'b1, i, ~pat(i));
      end

      // Reset asserted once addresses 0..7 have been issued (7 writes done).
      launch(3'd0, 8'd0);
      check("run_busy", 64'(busy), 64'd1);
      repeat (8) @(negedge clk50);
      check("pre_rst_diff", 64'(diff_count), 64'd7);
      reset = 1'b1;
      #1;
      check("mid_rst", {busy, done, 62'(diff_count)}, 64'd0);
      @(negedge clk50);
      reset = 1'b0;
      @(negedge clk50);
      launch(3'd0, 8'd0);
      finish_run("after_rst");
      check("after_rst_diff", 64'(diff_count), 64'd16);
      rd(0, r); check("after_rst_r0", 64'(r), 64'hFFFFFF);

      // B = A: every result zero.
      for (int i = 0; i < DEPTH; i++) wr(1'b1, i, pat(i));
      launch(3'd0, 8'd0);
      finish_run("equal");
      check("equal_diff", 64'(diff_count), 64'd0);
      acc = '0;
      for (int i = 0; i < DEPTH; i++) begin rd(i, r); acc = acc | r; end
      check("equal_or", 64'(acc), 64'd0);

      // B[3] written on the start edge must be seen by the compare.
      wr(1'b0, 3, 24'h0A0A0A);
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd3; wr_data = 24'h050F0A;
      launch(3'd0, 8'd4);
      wr_en = 1'b0;
      finish_run("abs_t4");
      check("abs_t4_diff", 64'(diff_count), 64'd1);
      rd(3, r); check("abs_r3", 64'(r), 64'h050500);
      rd(2, r); check("abs_r2", 64'(r), 64'h000000);

      launch(3'd0, 8'd5);
      finish_run("abs_t5");
      check("abs_t5_diff", 64'(diff_count), 64'd0);

      launch(3'd1, 8'd4); finish_run("min");
      rd(3, r); check("min_r3", 64'(r), 64'h050A0A);
      launch(3'd2, 8'd4); finish_run("max");
      rd(3, r); check("max_r3", 64'(r), 64'h0A0F0A);
      rd(5, r); check("max_r5", 64'(r), 64'h50A0F0);
      launch(3'd3, 8'd4); finish_run("xor");
      rd(3, r); check("xor_r3", 64'(r), 64'h0F0500);
      check("xor_diff", 64'(diff_count), 64'd1);
      launch(3'd4, 8'd4); finish_run("mask");
      rd(3, r); check("mask_r3", 64'(r), 64'hFFFFFF);
      rd(2, r); check("mask_r2", 64'(r), 64'h000000);
      launch(3'd6, 8'd4); finish_run("mode6");
      rd(3, r); check("mode6_r3", 64'(r), 64'h050500);

      // start and a load during RUN are both ignored.
      launch(3'd0, 8'd0);
      repeat (3) @(negedge clk50);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 24'hFFFFFF; start = 1'b1;
      @(negedge clk50);
      wr_en = 1'b0; start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 2 * DEPTH + 8; k++) begin
         @(negedge clk50);
         if (done) ndone++;
      end
      check("ign_done_cnt", 64'(ndone), 64'd1);
      launch(3'd0, 8'd0);
      finish_run("ign_chk");
      check("ign_diff", 64'(diff_count), 64'd1);
      rd(5, r); check("ign_r5", 64'(r), 64'h000000);

      // Sweep instance: 64 x 12-bit single channel, random data.
      for (int i = 0; i < D2; i++) begin
         ma[i] = CW2'($urandom_range(0, 4095));
         mb[i] = CW2'($urandom_range(0, 4095));
      end
      for (int i = 0; i < 2 * D2; i++) begin
         s_wr_en = 1'b1; s_wr_sel = (i >= D2); s_wr_addr = AW2'(i % D2);
         s_wr_data = (i >= D2) ? mb[i % D2] : ma[i % D2];
         @(negedge clk50);
      end
      s_wr_en = 1'b0;
      s_mode = 3'd0; s_threshold = 12'h700; s_start = 1'b1;
      @(negedge clk50);
      s_start = 1'b0;
      lat2 = -1;
      for (int k = 1; k <= D2 + 10; k++) begin
         @(negedge clk50);
         if (s_done) begin lat2 = k; break; end
      end
      check("sweep_lat", 64'(lat2), 64'(D2 + 2));
      cnt = 0;
      for (int i = 0; i < D2; i++) begin
         e = (ma[i] > mb[i]) ? (ma[i] - mb[i]) : (mb[i] - ma[i]);
         if (e > 12'h700) cnt++;
         s_rd_addr = AW2'(i);
         @(negedge clk50);
         check($sformatf("sweep_r%0d", i), 64'(s_rd_data), 64'(e));
      end
      check("sweep_diff", 64'(s_diff_count), 64'(cnt));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
